// File: rtl/tx_symbol_mapper.sv
// BPSK/QPSK/Gray-16QAM symbol mapper emitting SPS {I,Q} samples per symbol over valid/ready.
// Define TX_MAP_ZERO_STUFF_EN to zero-stuff samples 1..SPS-1 instead of sample-and-hold.
module tx_symbol_mapper #(
  parameter int OUT_W = 12,
  parameter int SPS   = 4,
  parameter int AMP   = 1536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  input  logic [3:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [2*OUT_W-1:0]   out_data,
  input  logic                 out_ready,
  output logic                 out_sos
);

  localparam int CW = $clog2(SPS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SPS - 1);
  localparam logic signed [OUT_W-1:0] AMP_P  = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0] AMP_N  = OUT_W'(-AMP);
  localparam logic signed [OUT_W-1:0] STEP_P = OUT_W'(AMP / 3);
  localparam logic signed [OUT_W-1:0] STEP_N = OUT_W'(-(AMP / 3));
  localparam logic signed [OUT_W-1:0] ZERO_L = {OUT_W{1'b0}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  // Gray-coded 4-level amplitude for one 16-QAM axis.
  function automatic logic signed [OUT_W-1:0] gray_level(input logic [1:0] bits);
    logic signed [OUT_W-1:0] lvl;
    case (bits)
      2'b00:   lvl = AMP_N;
      2'b01:   lvl = STEP_N;
      2'b11:   lvl = STEP_P;
      2'b10:   lvl = AMP_P;
      default: lvl = ZERO_L;
    endcase
    return lvl;
  endfunction

  function automatic logic [2*OUT_W-1:0] map_point(input logic [1:0] m, input logic [3:0] d);
    logic signed [OUT_W-1:0] i_v;
    logic signed [OUT_W-1:0] q_v;
    case (m)
      2'd0: begin
        i_v = d[0] ? AMP_P : AMP_N;
        q_v = ZERO_L;
      end
      2'd1: begin
        i_v = d[1] ? AMP_P : AMP_N;
        q_v = d[0] ? AMP_P : AMP_N;
      end
      2'd2: begin
        i_v = gray_level(d[3:2]);
        q_v = gray_level(d[1:0]);
      end
      default: begin
        i_v = ZERO_L;
        q_v = ZERO_L;
      end
    endcase
    return {i_v, q_v};
  endfunction

  state_t               state_r, state_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic [2*OUT_W-1:0]   data_r, data_nxt_s;
  logic                 sos_r, sos_nxt_s;
  logic [2*OUT_W-1:0]   mapped_s;
  logic [2*OUT_W-1:0]   follow_s;
  logic                 last_s;
  logic                 in_hs_s;

  assign mapped_s  = map_point(mode, in_data);
  assign last_s    = (cnt_r == LAST_CNT);
  assign in_ready  = (state_r == ST_IDLE) || (last_s && out_ready);
  assign in_hs_s   = in_valid && in_ready;
  assign out_valid = (state_r == ST_SEND);
  assign out_data  = data_r;
  assign out_sos   = sos_r;

`ifdef TX_MAP_ZERO_STUFF_EN
  assign follow_s = {(2*OUT_W){1'b0}};
`else
  assign follow_s = data_r;
`endif

  // Next-state: load on handshake, advance on accepted sample, hold under backpressure.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    data_nxt_s  = data_r;
    sos_nxt_s   = sos_r;
    case (state_r)
      ST_IDLE: begin
        if (in_hs_s) begin
          state_nxt_s = ST_SEND;
          cnt_nxt_s   = {CW{1'b0}};
          data_nxt_s  = mapped_s;
          sos_nxt_s   = 1'b1;
        end else begin
          sos_nxt_s   = 1'b0;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (!last_s) begin
            cnt_nxt_s  = cnt_r + CW'(1);
            data_nxt_s = follow_s;
            sos_nxt_s  = 1'b0;
          end else if (in_hs_s) begin
            cnt_nxt_s  = {CW{1'b0}};
            data_nxt_s = mapped_s;
            sos_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
            sos_nxt_s   = 1'b0;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        sos_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      data_r  <= {(2*OUT_W){1'b0}};
      sos_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      data_r  <= data_nxt_s;
      sos_r   <= sos_nxt_s;
    end
  end

endmodule

// File: tb/tb_tx_symbol_mapper.sv
// Self-checking bench for tx_symbol_mapper: queue-based sample model plus directed literal checks.
module tb_tx_symbol_mapper;

  localparam int OUT_W = 12;
  localparam int SPS   = 4;
  localparam int AMP   = 1536;
  localparam int STEP  = AMP / 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          mode;
  logic                in_valid;
  logic [3:0]          in_data;
  logic                in_ready;
  logic                out_valid;
  logic [2*OUT_W-1:0]  out_data;
  logic                out_ready;
  logic                out_sos;

  tx_symbol_mapper #(.OUT_W(OUT_W), .SPS(SPS), .AMP(AMP)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_sos(out_sos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*OUT_W-1:0] d;
    bit                 sos;
  } samp_t;

  samp_t q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;
  int    moves     = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic int axis_level(input logic [1:0] b);
    int idx;
    int lv[4];
    lv[0] = -AMP; lv[1] = -STEP; lv[2] = STEP; lv[3] = AMP;
    idx = b[1] ? (b[0] ? 2 : 3) : (b[0] ? 1 : 0);
    return lv[idx];
  endfunction

  function automatic logic [2*OUT_W-1:0] exp_point(input logic [1:0] m, input logic [3:0] d);
    int iv, qv;
    logic [OUT_W-1:0] ib, qb;
    case (m)
      2'd0: begin iv = d[0] ? AMP : -AMP; qv = 0; end
      2'd1: begin iv = d[1] ? AMP : -AMP; qv = d[0] ? AMP : -AMP; end
      2'd2: begin iv = axis_level(d[3:2]); qv = axis_level(d[1:0]); end
      default: begin iv = 0; qv = 0; end
    endcase
    ib = OUT_W'(iv);
    qb = OUT_W'(qv);
    return {ib, qb};
  endfunction

  // Model compare and update, evaluated between active edges.
  always @(negedge clk) begin
    samp_t s;
    logic [2*OUT_W-1:0] p;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_sos", {31'd0, out_sos}, 32'd0);
      chk("rst_out_data", {8'd0, out_data}, 32'd0);
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("in_ready", {31'd0, in_ready},
          {31'd0, (q.size() == 0) || (q.size() == 1 && out_ready)});
      if (q.size() > 0 && out_valid) begin
        chk("out_data", {8'd0, out_data}, {8'd0, q[0].d});
        chk("out_sos", {31'd0, out_sos}, {31'd0, q[0].sos});
      end
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        moves++;
      end
      if (in_valid && in_ready) begin
        p = exp_point(mode, in_data);
        for (int k = 0; k < SPS; k++) begin
`ifdef TX_MAP_ZERO_STUFF_EN
          s.d = (k == 0) ? p : '0;
`else
          s.d = p;
`endif
          s.sos = (k == 0);
          q.push_back(s);
        end
      end
    end
  end

  // Present one symbol; returns one clock after its handshake (first sample visible).
  task automatic send(input logic [1:0] m, input logic [3:0] d);
    bit done = 1'b0;
    mode = m; in_data = d; in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      done = !out_valid;
    end
    @(posedge clk);
    #1;
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_now(input string nm, input logic [2*OUT_W-1:0] d, input bit sos);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_data"}, {8'd0, out_data}, {8'd0, d});
    chk({nm, "_sos"}, {31'd0, out_sos}, {31'd0, sos});
  endtask

  initial begin
    int m0;
    rst_n = 1'b0; in_valid = 1'b0; mode = 2'd0; in_data = 4'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // QPSK 10 -> (+1536,-1536)
    send(2'd1, 4'b0010);
    chk_now("qpsk10", 24'h600A00, 1'b1);
    drain();

    // 16QAM back-to-back: 1101 -> (+512,-512), 0010 -> (-1536,+1536)
    send(2'd2, 4'b1101);
    chk_now("qam1101", 24'h200E00, 1'b1);
    send(2'd2, 4'b0010);
    chk_now("qam0010", 24'hA00600, 1'b1);
    drain();

    // BPSK with random upper bits
    send(2'd0, {3'($urandom_range(0, 7)), 1'b1});
    chk_now("bpsk1", 24'h600000, 1'b1);
    for (int k = 0; k < 3; k++) send(2'd0, {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))});
    drain();

    // Full 16QAM sweep back-to-back
    for (int k = 0; k < 16; k++) send(2'd2, 4'(k));
    drain();

    // Backpressure at sample 2
    m0 = moves;
    send(2'd1, 4'b0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
`ifdef TX_MAP_ZERO_STUFF_EN
    chk_now("stall", 24'h000000, 1'b0);
`else
    chk_now("stall", 24'hA00600, 1'b0);
`endif
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    drain();
    chk("stall_moves", moves - m0, 32'd4);

    // Asynchronous reset at sample 1
    send(2'd0, 4'b0000);
    chk_now("bpsk0", 24'hA00000, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(2'd1, 4'b0011);
    chk_now("after_rst", 24'h600600, 1'b1);
    @(posedge clk); #1;
`ifdef TX_MAP_ZERO_STUFF_EN
    chk_now("qpsk11_s1", 24'h000000, 1'b0);
`else
    chk_now("qpsk11_s1", 24'h600600, 1'b0);
`endif
    drain();

    // Reserved mode: consumed, emits zeros
    m0 = moves;
    send(2'd3, 4'hF);
    chk_now("mode3", 24'h000000, 1'b1);
    drain();
    chk("mode3_moves", moves - m0, 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
